fir_mac_sched: RTL and testbench

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_pkg.sv | 13 +
 rtl/tap_cnt.sv | 32 +++
 rtl/fir_mac_sched.sv | 134 +++++++++++++
 tb/tb_fir_mac_sched.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR MAC scheduler: default sizing and FSM encoding.
package fir_pkg;

  localparam int unsigned NTAPS_DEF  = 64;
  localparam int unsigned ADDR_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tap_cnt.sv
// Tap address counter: synchronous clear, count enable, terminal count at NTAPS-1.
module tap_cnt #(
  parameter int unsigned NTAPS  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_tc
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NTAPS - 1);

  logic [ADDR_W-1:0] r_cnt;

  // Counter register: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + ADDR_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == LAST);

endmodule

// File: rtl/fir_mac_sched.sv
// Two-channel FIR MAC scheduler: round-robin grant of L/R sample requests onto one
// shared multiplier, stepping NTAPS coefficient addresses per pass.
module fir_mac_sched
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS  = NTAPS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x_valid_l,
  input  logic              x_valid_r,
  input  logic              rising_tone,
  input  logic              ovr_clr,
  output logic [ADDR_W-1:0] tap_addr,
  output logic              ch_sel,
  output logic              coef_bank,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              y_en_l,
  output logic              y_en_r,
  output logic              busy,
  output logic [1:0]        overrun
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_pend_l;
  logic        r_pend_r;
  logic        r_last_ch;
  logic        r_ch_sel;
  logic        r_coef_bank;
  logic [1:0]  r_overrun;
  logic        w_gnt;
  logic        w_gnt_ch;
  logic        w_gnt_l;
  logic        w_gnt_r;
  logic [1:0]  w_ovr_set;
  logic        w_tc;
  logic        w_cnt_clr;
  logic        w_cnt_en;
  logic [ADDR_W-1:0] w_cnt;

  // Counter only runs in RUN; clearing on terminal count leaves it at 0 through DONE.
  assign w_cnt_en  = (r_state == RUN);
  assign w_cnt_clr = (r_state != RUN) || w_tc;

  tap_cnt #(
    .NTAPS  (NTAPS),
    .ADDR_W (ADDR_W)
  ) u_tap_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // Next-state and grant decision; on a tie the channel opposite last_ch wins.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt       = 1'b0;
    w_gnt_ch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend_l || r_pend_r) begin
          w_gnt       = 1'b1;
          w_gnt_ch    = r_pend_r && (!r_pend_l || !r_last_ch);
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_tc) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_gnt_l = w_gnt && !w_gnt_ch;
  assign w_gnt_r = w_gnt &&  w_gnt_ch;

  // A strobe only overruns if its pending bit survives this edge.
  assign w_ovr_set[0] = x_valid_l && r_pend_l && !w_gnt_l;
  assign w_ovr_set[1] = x_valid_r && r_pend_r && !w_gnt_r;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending requests, arbitration history, per-pass latches and sticky overrun flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_l    <= 1'b0;
      r_pend_r    <= 1'b0;
      r_last_ch   <= 1'b1;
      r_ch_sel    <= 1'b0;
      r_coef_bank <= 1'b0;
      r_overrun   <= '0;
    end else begin
      r_pend_l  <= x_valid_l || (r_pend_l && !w_gnt_l);
      r_pend_r  <= x_valid_r || (r_pend_r && !w_gnt_r);
      r_overrun <= w_ovr_set | (r_overrun & {2{!ovr_clr}});
      if (w_gnt) begin
        r_last_ch   <= w_gnt_ch;
        r_ch_sel    <= w_gnt_ch;
        r_coef_bank <= rising_tone;
      end
    end
  end

  assign tap_addr  = w_cnt;
  assign ch_sel    = r_ch_sel;
  assign coef_bank = r_coef_bank;
  assign acc_en    = (r_state == RUN);
  assign acc_clr   = (r_state == RUN) && (w_cnt == '0);
  assign y_en_l    = (r_state == DONE) && !r_ch_sel;
  assign y_en_r    = (r_state == DONE) &&  r_ch_sel;
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_fir_mac_sched.sv
// Self-checking bench for fir_mac_sched: directed scenarios plus random traffic,
// compared every cycle against a pass-phase reference model.
module tb_fir_mac_sched;

  localparam int unsigned NTAPS  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic              x_valid_l;
  logic              x_valid_r;
  logic              rising_tone;
  logic              ovr_clr;
  logic [ADDR_W-1:0] tap_addr;
  logic              ch_sel;
  logic              coef_bank;
  logic              acc_clr;
  logic              acc_en;
  logic              y_en_l;
  logic              y_en_r;
  logic              busy;
  logic [1:0]        overrun;

  fir_mac_sched #(
    .NTAPS  (NTAPS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x_valid_l   (x_valid_l),
    .x_valid_r   (x_valid_r),
    .rising_tone (rising_tone),
    .ovr_clr     (ovr_clr),
    .tap_addr    (tap_addr),
    .ch_sel      (ch_sel),
    .coef_bank   (coef_bank),
    .acc_clr     (acc_clr),
    .acc_en      (acc_en),
    .y_en_l      (y_en_l),
    .y_en_r      (y_en_r),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: m_phase = -1 when idle, 0..NTAPS-1 = tap being processed,
  // NTAPS = output-strobe cycle.
  int         m_phase;
  logic       m_pl, m_pr, m_last, m_ch, m_bank;
  logic [1:0] m_ovr;

  task automatic model_reset();
    m_phase = -1;
    m_pl = 1'b0; m_pr = 1'b0;
    m_last = 1'b1; m_ch = 1'b0; m_bank = 1'b0;
    m_ovr = 2'b00;
  endtask

  task automatic model_step(input logic vl, input logic vr, input logic rt, input logic oc);
    logic gl, gr;
    gl = 1'b0; gr = 1'b0;
    if (m_phase < 0 && (m_pl || m_pr)) begin
      if (m_pl && m_pr) begin
        if (m_last) gl = 1'b1; else gr = 1'b1;
      end else if (m_pl) begin
        gl = 1'b1;
      end else begin
        gr = 1'b1;
      end
    end
    m_ovr[0] = (vl && m_pl && !gl) || (m_ovr[0] && !oc);
    m_ovr[1] = (vr && m_pr && !gr) || (m_ovr[1] && !oc);
    m_pl = vl || (m_pl && !gl);
    m_pr = vr || (m_pr && !gr);
    if (gl || gr) begin
      m_phase = 0;
      m_ch    = gr;
      m_last  = gr;
      m_bank  = rt;
    end else if (m_phase >= 0 && m_phase < int'(NTAPS)) begin
      m_phase = m_phase + 1;
    end else if (m_phase == int'(NTAPS)) begin
      m_phase = -1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic in_run;
    in_run = (m_phase >= 0) && (m_phase < int'(NTAPS));
    chk("tap_addr",  32'(tap_addr),  in_run ? 32'(m_phase) : 32'd0);
    chk("ch_sel",    32'(ch_sel),    32'(m_ch));
    chk("coef_bank", 32'(coef_bank), 32'(m_bank));
    chk("acc_en",    32'(acc_en),    32'(in_run));
    chk("acc_clr",   32'(acc_clr),   32'(m_phase == 0));
    chk("y_en_l",    32'(y_en_l),    32'((m_phase == int'(NTAPS)) && !m_ch));
    chk("y_en_r",    32'(y_en_r),    32'((m_phase == int'(NTAPS)) && m_ch));
    chk("busy",      32'(busy),      32'(m_phase >= 0));
    chk("overrun",   32'(overrun),   32'(m_ovr));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare 1 time unit later.
  task automatic cyc(input logic vl, input logic vr, input logic rt, input logic oc);
    x_valid_l = vl; x_valid_r = vr; rising_tone = rt; ovr_clr = oc;
    @(posedge clk);
    model_step(vl, vr, rt, oc);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic do_reset();
    x_valid_l = 1'b0; x_valid_r = 1'b0; rising_tone = 1'b0; ovr_clr = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2;
    reset = 1'b1;
  endtask

  int n_edge, yen_edge, n_yl, n_yr, n_clr;
  int order[$];

  initial begin
    reset = 1'b0;
    x_valid_l = 1'b0; x_valid_r = 1'b0; rising_tone = 1'b0; ovr_clr = 1'b0;
    model_reset();
    #2;

    // Reset state and single L strobe: latency and tap walk.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_edge = 1; yen_edge = -1; n_yl = 0; n_yr = 0; n_clr = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      n_edge++;
      if (acc_clr) n_clr++;
      if (y_en_l) begin
        n_yl++;
        if (yen_edge < 0) yen_edge = n_edge;
      end
      if (y_en_r) n_yr++;
    end
    chk("single_chsel", 32'(ch_sel), 32'd0);
    chk("single_latency_edge", 32'(yen_edge + 1), 32'(NTAPS + 3));
    chk("single_yen_l_count", 32'(n_yl), 32'd1);
    chk("single_yen_r_count", 32'(n_yr), 32'd0);
    chk("single_accclr_count", 32'(n_clr), 32'd1);

    // Simultaneous pairs: L then R, twice.
    do_reset();
    order.delete();
    for (int p = 0; p < 2; p++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 140; k++) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        if (y_en_l) order.push_back(0);
        if (y_en_r) order.push_back(1);
      end
    end
    chk("tie_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("tie_order0", 32'(order[0]), 32'd0);
      chk("tie_order1", 32'(order[1]), 32'd1);
      chk("tie_order2", 32'(order[2]), 32'd0);
      chk("tie_order3", 32'(order[3]), 32'd1);
    end

    // Overrun on R during an L pass; ovr_clr loses to a simultaneous set.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovr_after_two_r", 32'(overrun), 32'h2);
    idle(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("ovr_clr_vs_set", 32'(overrun), 32'h2);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_cleared", 32'(overrun), 32'h0);
    idle(150);

    // Coefficient bank latched at grant, ignored afterwards.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 70; k++) begin
      cyc(1'b0, 1'b0, logic'(k % 2), 1'b0);
      if (busy) chk("bank_hold", 32'(coef_bank), 32'd1);
    end

    // Reset in the middle of a pass at tap 30.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(31);
    chk("midpass_tap", 32'(tap_addr), 32'd30);
    do_reset();
    n_yl = 0;
    for (int k = 0; k < 80; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (busy || y_en_l || y_en_r) n_yl++;
    end
    chk("post_reset_quiet", 32'(n_yl), 32'd0);

    // Strobe in the grant cycle re-queues the channel without overrun.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_yl = 0;
    for (int k = 0; k < 150; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (y_en_l) n_yl++;
    end
    chk("grant_strobe_passes", 32'(n_yl), 32'd2);
    chk("grant_strobe_ovr", 32'(overrun), 32'h0);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cyc(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 39) == 0),
          logic'($urandom_range(0, 1)), logic'($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
